vec_regfile_lmul_seq: RTL

Parametrised vector register file with a register-group read sequencer. It stores NUM_VREGS registers of VLEN bits and has one byte-masked write port. A read request names two source groups and one destination group plus LMUL; the block streams that request as LMUL beats on a valid/ready channel, one register per beat. It sits between the decode stage and the vector execution lanes of the vector processor datapath, replacing the single-cycle register file for LMUL > 1 operation.

---
 rtl/vec_regfile_lmul_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vec_regfile_lmul_seq.sv
// Vector register file with byte-masked write port and an LMUL register-group read sequencer.
// Latency: first beat 1 cycle after request accept, then 1 beat/cycle; writes visible 1 edge later.
// Backpressure: beat outputs hold while rd_valid && !rd_ready; no new request accepted while streaming.
module vec_regfile_lmul_seq #(
  parameter  int VLEN       = 512,
  parameter  int NUM_VREGS  = 32,
  parameter  int ADDR_WIDTH = $clog2(NUM_VREGS),
  localparam int VL_WIDTH   = $clog2(8*VLEN)+1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] vd_addr,
  input  logic [3:0]            lmul,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [VLEN-1:0]       rdata_1,
  output logic [VLEN-1:0]       rdata_2,
  output logic [VLEN-1:0]       dst_data,
  output logic [2:0]            rd_beat,
  output logic                  rd_last,
  output logic [VL_WIDTH-1:0]   vector_length,
  output logic                  wrong_addr,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [VLEN-1:0]       wdata,
  input  logic [VLEN/8-1:0]     wr_be
);

  localparam int NB  = VLEN/8;
  localparam int AW4 = ADDR_WIDTH+4;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state;
  logic [VLEN-1:0]       regs [NUM_VREGS];
  logic [ADDR_WIDTH-1:0] rs1_q, rs2_q, vd_q;
  logic [3:0]            lmul_q;

  logic [VLEN-1:0]       wmerge;
  logic [2:0]            ld_k;
  logic [ADDR_WIDTH-1:0] a1, a2, ad;
  logic [VLEN-1:0]       nxt1, nxt2, nxtd;
  logic [3:0]            lmul_m1;
  logic                  legal;

  assign rd_req_ready = (state == IDLE) && !reset;

  // Post-write contents of the register being written, used for both the array update and the read bypass
  always_comb begin
    wmerge = regs[waddr];
    for (int i = 0; i < NB; i++) begin
      if (wr_be[i]) wmerge[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  // Address and bypassed data of the beat that would be loaded at the next edge
  always_comb begin
    if (state == IDLE) begin
      ld_k = 3'd0;
      a1   = rs1_addr;
      a2   = rs2_addr;
      ad   = vd_addr;
    end else begin
      ld_k = rd_beat + 3'd1;
      a1   = rs1_q + ADDR_WIDTH'(ld_k);
      a2   = rs2_q + ADDR_WIDTH'(ld_k);
      ad   = vd_q  + ADDR_WIDTH'(ld_k);
    end
    nxt1 = (wr_en && waddr == a1) ? wmerge : regs[a1];
    nxt2 = (wr_en && waddr == a2) ? wmerge : regs[a2];
    nxtd = (wr_en && waddr == ad) ? wmerge : regs[ad];
  end

  // Group legality: power-of-two LMUL up to 8, every base aligned to the group size
  always_comb begin
    lmul_m1 = lmul - 4'd1;
    legal   = (lmul == 4'd1 || lmul == 4'd2 || lmul == 4'd4 || lmul == 4'd8) &&
              ((AW4'(rs1_addr) & AW4'(lmul_m1)) == '0) &&
              ((AW4'(rs2_addr) & AW4'(lmul_m1)) == '0) &&
              ((AW4'(vd_addr)  & AW4'(lmul_m1)) == '0);
  end

  // Register array: byte-masked write, cleared by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_VREGS; r++) regs[r] <= '0;
    end else if (wr_en) begin
      regs[waddr] <= wmerge;
    end
  end

  // Sequencer: accept/check request, then stream one register of each group per handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rd_valid      <= 1'b0;
      rd_beat       <= 3'd0;
      rd_last       <= 1'b0;
      rdata_1       <= '0;
      rdata_2       <= '0;
      dst_data      <= '0;
      vector_length <= '0;
      wrong_addr    <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      vd_q          <= '0;
      lmul_q        <= '0;
    end else begin
      wrong_addr <= 1'b0;
      case (state)
        IDLE: begin
          if (rd_req_valid) begin
            if (legal) begin
              rs1_q         <= rs1_addr;
              rs2_q         <= rs2_addr;
              vd_q          <= vd_addr;
              lmul_q        <= lmul;
              rdata_1       <= nxt1;
              rdata_2       <= nxt2;
              dst_data      <= nxtd;
              rd_beat       <= 3'd0;
              rd_valid      <= 1'b1;
              rd_last       <= (lmul == 4'd1);
              vector_length <= VL_WIDTH'(VLEN * int'(lmul));
              state         <= STREAM;
            end else begin
              wrong_addr <= 1'b1;
            end
          end
        end
        STREAM: begin
          // flush wins over a handshake in the same cycle
          if (flush) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            state    <= IDLE;
          end else if (rd_ready) begin
            if (rd_last) begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              state    <= IDLE;
            end else begin
              rdata_1  <= nxt1;
              rdata_2  <= nxt2;
              dst_data <= nxtd;
              rd_beat  <= ld_k;
              rd_last  <= ({1'b0, ld_k} == lmul_q - 4'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
